// File: rtl/hs32_wb_master_pkg.sv
// Shared definitions for the hs32 Wishbone initiator and the core bus unit that
// decodes its response codes.
package hs32_wb_master_pkg;

  localparam logic [1:0] WB_IDLE = 2'd0;
  localparam logic [1:0] WB_BUS  = 2'd1;
  localparam logic [1:0] WB_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = WB_IDLE,
    ST_BUS  = WB_BUS,
    ST_RESP = WB_RESP
  } wb_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  // Bit positions inside the response code, shared with the hs32 bus unit.
  localparam int RESP_ERR_BIT     = 0;
  localparam int RESP_TIMEOUT_BIT = 1;
  localparam int RESP_CODE_W      = 2;

  function automatic logic [RESP_CODE_W-1:0] resp_code(input logic err, input logic timeout);
    logic [RESP_CODE_W-1:0] code;
    code                   = '0;
    code[RESP_ERR_BIT]     = err;
    code[RESP_TIMEOUT_BIT] = timeout;
    return code;
  endfunction

endpackage

// File: rtl/hs32_wb_master_watchdog.sv
// Saturating wait counter; expire is high while the count sits on the last
// permitted wait cycle.
module hs32_wb_watchdog
  import hs32_wb_master_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != SAT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = (r_count == LAST);

endmodule

// File: rtl/hs32_wb_master.sv
// Wishbone B4 classic initiator: one valid/ready request becomes one bus cycle,
// with a watchdog that aborts cycles the slave never terminates.
module hs32_wb_master
  import hs32_wb_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_sel,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                resp_timeout,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);

  localparam int SEL_W = DATA_W / 8;

  wb_state_e r_state;
  wb_state_e w_state_next;

  logic                   r_req_ready;
  logic                   r_cyc;
  logic                   r_stb;
  logic                   r_we;
  logic [SEL_W-1:0]       r_sel;
  logic [ADDR_W-1:0]      r_adr;
  logic [DATA_W-1:0]      r_dat_o;
  logic                   r_resp_valid;
  logic [DATA_W-1:0]      r_resp_rdata;
  logic                   r_resp_err;
  logic                   r_resp_timeout;
  logic [RESP_CODE_W-1:0] r_code;
  logic [RESP_CODE_W-1:0] w_code_next;

  logic w_accept;
  logic w_bus_done;
  logic w_finish;
  logic w_expire;
  logic w_wd_enable;
  logic w_capture;

  assign w_accept    = req_valid && r_req_ready;
  assign w_bus_done  = wbm_ack_i || wbm_err_i;
  assign w_wd_enable = (r_state == ST_BUS) && !w_bus_done;
  assign w_capture   = (r_state == ST_BUS) && w_bus_done && !r_we;

  hs32_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (wb_clk_i),
    .i_srst   (wb_rst_i),
    .i_clear  (w_accept),
    .i_enable (w_wd_enable),
    .o_expire (w_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A slave termination in the expiring cycle takes precedence over the abort.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_BUS;
          w_code_next  = '0;
        end
      end
      ST_BUS: begin
        if (w_bus_done) begin
          w_state_next = ST_RESP;
          w_code_next  = resp_code(wbm_err_i, 1'b0);
          w_finish     = 1'b1;
        end else if (w_expire) begin
          w_state_next = ST_RESP;
          w_code_next  = resp_code(1'b1, 1'b1);
          w_finish     = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Response flags are presented one edge after RESP so they only exist
  // alongside resp_valid.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_req_ready    <= 1'b0;
      r_cyc          <= 1'b0;
      r_stb          <= 1'b0;
      r_we           <= 1'b0;
      r_sel          <= '0;
      r_adr          <= '0;
      r_dat_o        <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_rdata   <= '0;
      r_resp_err     <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_code         <= '0;
    end else begin
      r_req_ready    <= (w_state_next == ST_IDLE);
      r_code         <= w_code_next;
      r_resp_valid   <= (r_state == ST_RESP);
      r_resp_err     <= (r_state == ST_RESP) && r_code[RESP_ERR_BIT];
      r_resp_timeout <= (r_state == ST_RESP) && r_code[RESP_TIMEOUT_BIT];
      if (w_accept) begin
        r_we    <= req_we;
        r_adr   <= req_addr;
        r_dat_o <= req_wdata;
        r_sel   <= req_sel;
        r_cyc   <= 1'b1;
        r_stb   <= 1'b1;
      end else if (w_finish) begin
        r_cyc <= 1'b0;
        r_stb <= 1'b0;
      end
      if (w_capture) begin
        r_resp_rdata <= wbm_dat_i;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_err     = r_resp_err;
  assign resp_timeout = r_resp_timeout;
  assign wbm_cyc_o    = r_cyc;
  assign wbm_stb_o    = r_stb;
  assign wbm_we_o     = r_we;
  assign wbm_sel_o    = r_sel;
  assign wbm_adr_o    = r_adr;
  assign wbm_dat_o    = r_dat_o;

endmodule

// File: doc/hs32_wb_master.md
Name: hs32_wb_master

Overview:
- Wishbone B4 classic initiator for the hs32 core; the counterpart of the core's existing Wishbone slave port.
- Converts a single-outstanding valid/ready request from the core into one Wishbone cycle and returns the read data or an error.
- Includes a watchdog that ends cycles which never receive ACK or ERR.
- Sits between the hs32 core bus unit and a shared Wishbone interconnect in the user area.

Parameters:
- ADDR_W, 32, request and Wishbone address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, maximum wait cycles per bus cycle before an abort; range 1..65535.

Ports:
- wb_clk_i  in  1  sole clock; all logic on the rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_sel  in  DATA_W/8  byte enables.
- resp_valid  out  1  one-cycle pulse marking a completed cycle.
- resp_rdata  out  DATA_W  read data; valid only with resp_valid.
- resp_err  out  1  with resp_valid: 1 means ERR or timeout.
- resp_timeout  out  1  with resp_valid: 1 means the abort came from the watchdog.
- wbm_cyc_o  out  1  Wishbone CYC.
- wbm_stb_o  out  1  Wishbone STB.
- wbm_we_o  out  1  Wishbone WE.
- wbm_sel_o  out  DATA_W/8  Wishbone SEL.
- wbm_adr_o  out  ADDR_W  Wishbone ADR.
- wbm_dat_o  out  DATA_W  Wishbone write data.
- wbm_dat_i  in  DATA_W  Wishbone read data.
- wbm_ack_i  in  1  Wishbone ACK.
- wbm_err_i  in  1  Wishbone ERR.

Behaviour:
- Reset (synchronous, wb_rst_i high at the clock edge):
  - State goes to IDLE.
  - All outputs are 0: cyc, stb, we, sel, adr, dat_o, resp_valid, resp_rdata, resp_err, resp_timeout, req_ready.
  - Reset has priority over every other event.
  - Reset during BUS drops CYC and STB on the next edge. No response is issued and the transaction is discarded.
- States:
  - IDLE: req_ready=1.
    - On accept, register we, addr, wdata and sel into the Wishbone outputs.
    - Assert cyc=stb=1, clear the wait counter, go to BUS.
  - BUS: req_ready=0; cyc and stb held; outputs stable.
    - ACK or ERR sampled high: deassert cyc and stb on the same edge, capture wbm_dat_i into resp_rdata on reads, go to RESP.
    - ACK and ERR both high: treated as ERR.
    - Otherwise the counter increments. When counter == TIMEOUT-1 with no ACK/ERR: deassert cyc and stb, set err=1 and timeout=1, go to RESP.
    - An ACK arriving in that same cycle wins over the timeout.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
- Latency:
  - With a zero-wait slave (ACK in the first BUS cycle), the request is accepted at edge 0 and resp_valid is high in the cycle after edge 2.
  - Next request accepted at edge 3; maximum throughput is one transfer per 3 cycles.
- Read data:
  - resp_rdata holds its last value outside resp_valid.
  - On writes, resp_rdata is unchanged.
- Abort:
  - A timeout aborts the cycle by dropping CYC.
  - A late ACK arriving while in IDLE or RESP is ignored.
- The watchdog counter is ceil(log2(TIMEOUT+1)) bits and saturates; there is no wrap.
- resp_err and resp_timeout are 0 whenever resp_valid is 0.
- Wishbone outputs hold their last values while cyc=0; slaves must qualify on CYC and STB.
- req_valid may drop without acceptance; no request is latched outside IDLE.

Decomposition:
- Shared package:
  - Wishbone state encoding localparams (IDLE=2'd0, BUS=2'd1, RESP=2'd2).
  - Default TIMEOUT constant.
  - The response-code bit positions reused by the hs32 bus unit.
- One sub-module: hs32_wb_watchdog (clear, enable, expire), the parameterised saturating counter.
- The FSM and registers stay in the top module.

Test Plan:
- Zero-wait read:
  - Stimulus: request read at addr 0x0000_0010; slave gives ACK in the first BUS cycle with dat_i=0xDEAD_BEEF.
  - Required: cyc high for exactly 1 cycle; resp_valid one pulse with rdata=0xDEAD_BEEF and err=0.
- Waited write:
  - Stimulus: write addr 0x40, wdata 0x1234_5678, sel=4'b0011; slave ACKs after 5 wait cycles.
  - Required: adr, dat_o and sel stable for all 6 BUS cycles; resp_valid with err=0.
- Error response:
  - Stimulus: slave asserts ERR on the first cycle.
  - Required: resp_err=1, resp_timeout=0; then a back-to-back request is accepted exactly 3 cycles after the first accept.
- Timeout:
  - Stimulus: TIMEOUT=8; slave never responds.
  - Required: cyc drops after 8 BUS cycles; resp_err=1, resp_timeout=1; a stray ACK arriving 2 cycles later causes no response.
- Reset mid-cycle:
  - Stimulus: assert wb_rst_i in the 3rd BUS cycle.
  - Required: all outputs 0 on the next edge; no resp_valid; req_ready=1 after reset is released.
- Simultaneous ACK and ERR, and ACK exactly on the timeout cycle:
  - Required: ACK+ERR gives err=1; ACK on the timeout cycle gives err=0 and timeout=0.
